// File: rtl/act_arb_pkg.sv
// Shared types and constants for the activation-stage arbiter.
package act_arb_pkg;

    localparam int LANES  = 64;
    localparam int DATA_W = 16;
    localparam int STAT_W = 16;

    // One activation vector: LANES signed Q4.12 lanes.
    typedef logic signed [DATA_W-1:0] vec_t [LANES];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/act_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, searching upward with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);
    import act_arb_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    // Walk the requesters starting at rr_ptr; the first hit wins.
    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = ID_W'(cand);
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/act_arbiter.sv
// Round-robin arbiter sharing one activation stage between NUM_REQ layer
// engines. One vector is accepted per grant, issued to the stage for one
// cycle, and the result is returned tagged with the requester id.
// Optional statistics counters are enabled by defining ACT_ARB_STATS_EN.
module act_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int LANES       = act_arb_pkg::LANES,
    parameter int DATA_W      = act_arb_pkg::DATA_W,
    parameter int ACT_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*LANES*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              act_valid_o,
    output logic [LANES*DATA_W-1:0]           act_data_o,
    input  logic [LANES*DATA_W-1:0]           act_data_i,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [LANES*DATA_W-1:0]           rsp_data,
`ifdef ACT_ARB_STATS_EN
    output logic [NUM_REQ*act_arb_pkg::STAT_W-1:0] grant_cnt,
    output logic [act_arb_pkg::STAT_W-1:0]         stall_cnt,
`endif
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id
);
    import act_arb_pkg::*;

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int VEC_W = LANES * DATA_W;
    localparam int CNT_W = (ACT_LATENCY > 1) ? $clog2(ACT_LATENCY) : 1;

    state_t             state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    id_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [VEC_W-1:0]   operand_reg;

    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [ID_W-1:0]    ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant_onehot),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Grant is visible in the same cycle, but only while idle.
    assign req_ready  = (state_reg == IDLE && !reset) ? grant_onehot : '0;
    assign ptr_next   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    // The stage sees the operand register directly; it holds between issues.
    assign act_data_o = operand_reg;

    // Main control FSM: accept, issue, wait for stage latency, hold result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            id_reg      <= '0;
            cnt_reg     <= '0;
            operand_reg <= '0;
            act_valid_o <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= '0;
        end else begin
            act_valid_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        operand_reg <= req_data[int'(grant_idx)*VEC_W +: VEC_W];
                        id_reg      <= grant_idx;
                        rr_ptr_reg  <= ptr_next;
                        act_valid_o <= 1'b1;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_reg   <= CNT_W'(ACT_LATENCY - 1);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        rsp_data  <= act_data_i;
                        rsp_id    <= id_reg;
                        rsp_valid <= 1'b1;
                        state_reg <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ACT_ARB_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
            logic [STAT_W-1:0] gcnt_reg;
            // Saturating count of accept pulses for this requester.
            always_ff @(posedge clk) begin
                if (reset) begin
                    gcnt_reg <= '0;
                end else if (req_ready[gi] && gcnt_reg != '1) begin
                    gcnt_reg <= gcnt_reg + 1'b1;
                end
            end
            assign grant_cnt[gi*STAT_W +: STAT_W] = gcnt_reg;
        end
    endgenerate

    logic [STAT_W-1:0] stall_reg;
    // Saturating count of cycles the result sat unaccepted downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_reg <= '0;
        end else if (state_reg == HOLD && !rsp_ready && stall_reg != '1) begin
            stall_reg <= stall_reg + 1'b1;
        end
    end
    assign stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_act_arbiter.sv
`timescale 1ns/1ps
module tb_act_arbiter;
    import act_arb_pkg::*;

    localparam int NR = 4;
    localparam int VW = LANES * DATA_W;
    localparam int SW = STAT_W;

    localparam int K_REQ_READY = 0, K_ACT_VALID = 1, K_RSP_VALID = 2, K_RSP_ID = 3;
    localparam int K_ACT_D0 = 4, K_RSP_D0 = 5, K_RSP_D1 = 6;
    localparam int K_B_REQ_READY = 7, K_B_ACT_VALID = 8, K_B_RSP_VALID = 9;
    localparam int K_SBA_LEFT = 10, K_SBB_LEFT = 11;
    localparam int K_A_GCNT = 20, K_A_STALL = 30, K_B_GCNT1 = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // DUT A: latency 1
    logic [NR-1:0]    a_req_valid = '0, a_req_ready;
    logic [NR*VW-1:0] a_req_data = '0;
    logic             a_act_valid, a_rsp_valid;
    logic             a_rsp_ready = 1'b1;
    logic [VW-1:0]    a_act_do, a_act_di, a_rsp_data;
    logic [1:0]       a_rsp_id;
    // DUT B: latency 3
    logic [NR-1:0]    b_req_valid = '0, b_req_ready;
    logic [NR*VW-1:0] b_req_data = '0;
    logic             b_act_valid, b_rsp_valid;
    logic             b_rsp_ready = 1'b1;
    logic [VW-1:0]    b_act_do, b_act_di, b_rsp_data;
    logic [1:0]       b_rsp_id;
`ifdef ACT_ARB_STATS_EN
    logic [NR*SW-1:0] a_grant_cnt, b_grant_cnt;
    logic [SW-1:0]    a_stall_cnt, b_stall_cnt;
`endif

    act_arbiter #(.NUM_REQ(NR), .ACT_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_data(a_req_data), .req_ready(a_req_ready),
        .act_valid_o(a_act_valid), .act_data_o(a_act_do), .act_data_i(a_act_di),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
`ifdef ACT_ARB_STATS_EN
        .grant_cnt(a_grant_cnt), .stall_cnt(a_stall_cnt),
`endif
        .rsp_id(a_rsp_id)
    );

    act_arbiter #(.NUM_REQ(NR), .ACT_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
        .act_valid_o(b_act_valid), .act_data_o(b_act_do), .act_data_i(b_act_di),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
`ifdef ACT_ARB_STATS_EN
        .grant_cnt(b_grant_cnt), .stall_cnt(b_stall_cnt),
`endif
        .rsp_id(b_rsp_id)
    );

    function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int i = 0; i < LANES; i++)
            if (v[i*DATA_W + DATA_W - 1]) r[i*DATA_W +: DATA_W] = '0;
        return r;
    endfunction

    function automatic logic [VW-1:0] gen_vec(input int r, input logic [15:0] salt);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*DATA_W +: DATA_W] = 16'(r * 4369 + i * 1057) ^ salt;
        return v;
    endfunction

    // Activation stage models: ReLU result valid only ACT_LATENCY cycles
    // after the issue strobe, poison otherwise.
    logic [VW-1:0] a_pd;
    logic          a_pv = 1'b0;
    always @(posedge clk) begin
        a_pd <= relu_vec(a_act_do);
        a_pv <= a_act_valid;
    end
    assign a_act_di = a_pv ? a_pd : {LANES{16'hDEAD}};

    logic [VW-1:0] b_pd [3];
    logic [2:0]    b_pv = '0;
    always @(posedge clk) begin
        b_pd[0] <= relu_vec(b_act_do);
        b_pd[1] <= b_pd[0];
        b_pd[2] <= b_pd[1];
        b_pv    <= {b_pv[1:0], b_act_valid};
    end
    assign b_act_di = b_pv[2] ? b_pd[2] : {LANES{16'hDEAD}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int kind; logic [31:0] val; } exp_t;
    typedef struct { logic [1:0] id; logic [VW-1:0] data; } rsp_t;
    exp_t exp_q[$];
    exp_t rest_q[$];
    rsp_t sba_q[$];
    rsp_t sbb_q[$];
    rsp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic string kname(input int k);
        case (k)
            K_REQ_READY:   return "req_ready";
            K_ACT_VALID:   return "act_valid_o";
            K_RSP_VALID:   return "rsp_valid";
            K_RSP_ID:      return "rsp_id";
            K_ACT_D0:      return "act_data_o_lane0";
            K_RSP_D0:      return "rsp_data_lane0";
            K_RSP_D1:      return "rsp_data_lane1";
            K_B_REQ_READY: return "b_req_ready";
            K_B_ACT_VALID: return "b_act_valid_o";
            K_B_RSP_VALID: return "b_rsp_valid";
            K_SBA_LEFT:    return "a_responses_outstanding";
            K_SBB_LEFT:    return "b_responses_outstanding";
            K_A_STALL:     return "stall_cnt";
            K_B_GCNT1:     return "b_grant_cnt1";
            default:       return $sformatf("grant_cnt%0d", k - K_A_GCNT);
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_REQ_READY:   return 32'(a_req_ready);
            K_ACT_VALID:   return 32'(a_act_valid);
            K_RSP_VALID:   return 32'(a_rsp_valid);
            K_RSP_ID:      return 32'(a_rsp_id);
            K_ACT_D0:      return 32'(a_act_do[15:0]);
            K_RSP_D0:      return 32'(a_rsp_data[15:0]);
            K_RSP_D1:      return 32'(a_rsp_data[31:16]);
            K_B_REQ_READY: return 32'(b_req_ready);
            K_B_ACT_VALID: return 32'(b_act_valid);
            K_B_RSP_VALID: return 32'(b_rsp_valid);
            K_SBA_LEFT:    return 32'(sba_q.size());
            K_SBB_LEFT:    return 32'(sbb_q.size());
`ifdef ACT_ARB_STATS_EN
            K_A_STALL:     return 32'(a_stall_cnt);
            K_B_GCNT1:     return 32'(b_grant_cnt[SW +: SW]);
            K_A_GCNT + 0:  return 32'(a_grant_cnt[0 +: SW]);
            K_A_GCNT + 1:  return 32'(a_grant_cnt[SW +: SW]);
`endif
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    task automatic chk(input int kind, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", kname(kind), cyc, act, req);
        end
    endtask

    task automatic chk_rsp(input string nm, input logic [1:0] id, input logic [VW-1:0] d, input rsp_t e);
        int bad;
        bad = -1;
        for (int i = LANES - 1; i >= 0; i--)
            if (d[i*DATA_W +: DATA_W] !== e.data[i*DATA_W +: DATA_W]) bad = i;
        n_checks++;
        if (id !== e.id || bad >= 0) begin
            n_fail++;
            if (bad < 0) bad = 0;
            $display("FAIL %s cycle=%0d actual id=%0d lane%0d=%h required id=%0d lane%0d=%h",
                     nm, cyc, id, bad, d[bad*DATA_W +: DATA_W], e.id, bad, e.data[bad*DATA_W +: DATA_W]);
        end else begin
            $display("%s cycle=%0d id=%0d lane0=%h ok", nm, cyc, id, d[15:0]);
        end
    endtask

    // Monitor: timed expectations plus response scoreboards.
    initial begin
        forever begin
            @(negedge clk);
            rest_q.delete();
            foreach (exp_q[i]) begin
                if (exp_q[i].cyc == cyc) begin
                    chk(exp_q[i].kind, actual(exp_q[i].kind), exp_q[i].val);
                end else if (exp_q[i].cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s expired cycle=%0d", kname(exp_q[i].kind), exp_q[i].cyc);
                end else begin
                    rest_q.push_back(exp_q[i]);
                end
            end
            exp_q = rest_q;
            if (a_rsp_valid && a_rsp_ready) begin
                if (sba_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_rsp_unexpected actual id=%0d required none", a_rsp_id);
                end else begin
                    mon_e = sba_q.pop_front();
                    chk_rsp("a_rsp", a_rsp_id, a_rsp_data, mon_e);
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (sbb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_rsp_unexpected actual id=%0d required none", b_rsp_id);
                end else begin
                    mon_e = sbb_q.pop_front();
                    chk_rsp("b_rsp", b_rsp_id, b_rsp_data, mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int d, input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc = cyc + d; e.kind = kind; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One request from r on DUT A; result held 'stall' cycles; 'pend' is
    // raised right after the grant. Returns in the cycle the DUT is idle.
    task automatic do_req_a(input int r, input int stall, input logic [NR-1:0] pend,
                            input logic [VW-1:0] v);
        rsp_t e;
        logic [VW-1:0] rv;
        rv = relu_vec(v);
        a_req_data[r*VW +: VW] = v;
        a_req_valid = '0;
        a_req_valid[r] = 1'b1;
        a_rsp_ready = (stall == 0);
        exp_at(0, K_REQ_READY, 32'(1) << r);
        exp_at(1, K_ACT_VALID, 1);
        exp_at(1, K_ACT_D0, 32'(v[15:0]));
        exp_at(2, K_ACT_VALID, 0);
        exp_at(2, K_RSP_VALID, 0);
        for (int s = 0; s <= stall; s++) begin
            exp_at(3 + s, K_RSP_VALID, 1);
            exp_at(3 + s, K_RSP_ID, 32'(r));
            exp_at(3 + s, K_RSP_D0, 32'(rv[15:0]));
        end
        for (int d = 1; d <= 3 + stall; d++) exp_at(d, K_REQ_READY, 0);
        exp_at(4 + stall, K_RSP_VALID, 0);
        e.id = 2'(r); e.data = rv;
        sba_q.push_back(e);
        tick();
        a_req_valid = pend;
        tick();
        tick();
        repeat (stall) tick();
        a_rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        logic [VW-1:0] v;
        rsp_t e;

        // Reset values
        do_reset();
        exp_at(0, K_REQ_READY, 0);
        exp_at(0, K_ACT_VALID, 0);
        exp_at(0, K_RSP_VALID, 0);
        exp_at(0, K_RSP_ID, 0);
        exp_at(0, K_RSP_D0, 0);
        exp_at(0, K_ACT_D0, 0);
        exp_at(0, K_B_RSP_VALID, 0);
        tick();

        // Single request with a negative lane
        v = gen_vec(2, 16'h0000);
        v[15:0]  = 16'h1000;
        v[31:16] = 16'hF000;
        exp_at(3, K_RSP_D1, 0);
        do_req_a(2, 0, '0, v);

        // Backpressure: 10 stall cycles with requester 3 waiting
        do_req_a(1, 10, 4'b1000, gen_vec(1, 16'h5A5A));
        do_req_a(3, 0, '0, gen_vec(3, 16'h8001));

        // Fairness: all requesters continuously valid
        do_reset();
        for (int r = 0; r < NR; r++) a_req_data[r*VW +: VW] = gen_vec(r, 16'h3C00);
        a_req_valid = '1;
        a_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_at(4*k, K_REQ_READY, 32'(1) << (k % NR));
            exp_at(4*k + 1, K_ACT_VALID, 1);
            exp_at(4*k + 2, K_REQ_READY, 0);
            exp_at(4*k + 3, K_REQ_READY, 0);
            exp_at(4*k + 3, K_RSP_VALID, 1);
            exp_at(4*k + 3, K_RSP_ID, 32'(k % NR));
            e.id = 2'(k % NR); e.data = relu_vec(gen_vec(k % NR, 16'h3C00));
            sba_q.push_back(e);
        end
        repeat (17) tick();
        a_req_valid = '0;
        repeat (4) tick();

        // Reset while waiting for the stage result
        a_req_data[2*VW +: VW] = gen_vec(2, 16'h7777);
        a_req_valid = 4'b0100;
        exp_at(0, K_REQ_READY, 32'b0100);
        tick();
        a_req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_req_data[0 +: VW]    = gen_vec(0, 16'h1234);
        a_req_data[3*VW +: VW] = gen_vec(3, 16'h4321);
        a_req_valid = 4'b1001;
        exp_at(0, K_RSP_VALID, 0);
        exp_at(0, K_ACT_VALID, 0);
        exp_at(0, K_REQ_READY, 32'b0001);
        exp_at(3, K_RSP_VALID, 1);
        exp_at(3, K_RSP_ID, 0);
        e.id = 2'd0; e.data = relu_vec(gen_vec(0, 16'h1234));
        sba_q.push_back(e);
        tick();
        a_req_valid = '0;
        repeat (3) tick();

        // Five grants to requester 1, seven stall cycles in total
        do_reset();
        do_req_a(1, 7, '0, gen_vec(1, 16'h0F0F));
        for (int k = 0; k < 4; k++) do_req_a(1, 0, '0, gen_vec(1, 16'(k * 16'h1111)));
`ifdef ACT_ARB_STATS_EN
        exp_at(0, K_A_GCNT + 1, 5);
        exp_at(0, K_A_GCNT + 0, 0);
        exp_at(0, K_A_STALL, 7);
`endif
        tick();

        // Latency-3 stage
        v = gen_vec(1, 16'hA5A5);
        b_req_data[VW +: VW] = v;
        b_req_valid = 4'b0010;
        b_rsp_ready = 1'b1;
        exp_at(0, K_B_REQ_READY, 32'b0010);
        exp_at(1, K_B_ACT_VALID, 1);
        exp_at(2, K_B_ACT_VALID, 0);
        exp_at(4, K_B_RSP_VALID, 0);
        exp_at(5, K_B_RSP_VALID, 1);
        e.id = 2'd1; e.data = relu_vec(v);
        sbb_q.push_back(e);
        tick();
        b_req_valid = '0;
        repeat (6) tick();
`ifdef ACT_ARB_STATS_EN
        exp_at(0, K_B_GCNT1, 1);
`endif

        // Every queued response must have been delivered
        exp_at(0, K_SBA_LEFT, 0);
        exp_at(0, K_SBB_LEFT, 0);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
